// File: rtl/bmp_binarize_ctrl.sv
// bmp_binarize_ctrl: in-place binarizer for a 24-bit BMP held in a dual-port RAM.
// Define BIN_WHITE_CNT_EN to add the white_cnt output (number of pixels written as 8'hFF).
`ifndef BYTE_WIDTH
`define BYTE_WIDTH 8
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 20
`endif
`ifndef BMP_TOTAL_SIZE
`define BMP_TOTAL_SIZE 786486
`endif

module bmp_binarize_ctrl #(
  parameter int DATA_START = 54,
  parameter int DATA_END   = `BMP_TOTAL_SIZE
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [`BYTE_WIDTH-1:0]   thr,
  output logic                     busy,
  output logic                     done,
  output logic                     RAM_ren1,
  output logic                     RAM_wen1,
  output logic [`ADDR_WIDTH-1:0]   RAM_addr1,
  output logic [`BYTE_WIDTH-1:0]   RAM_D1,
  input  logic [`BYTE_WIDTH-1:0]   RAM_Q1,
  output logic                     RAM_ren2,
  output logic                     RAM_wen2,
  output logic [`ADDR_WIDTH-1:0]   RAM_addr2,
  output logic [`BYTE_WIDTH-1:0]   RAM_D2
`ifdef BIN_WHITE_CNT_EN
  ,
  output logic [`ADDR_WIDTH-1:0]   white_cnt
`endif
);
  localparam int AW = `ADDR_WIDTH;
  localparam int BW = `BYTE_WIDTH;
  localparam int SW = BW + 2;
  localparam bit EMPTY = (DATA_END - DATA_START) < 3;
  localparam logic [AW:0] END_X = (AW+1)'(DATA_END);
  localparam logic [AW-1:0] P0 = AW'(DATA_START);

  typedef enum logic [3:0] {IDLE, RD0, RD1, RD2, RD3, CMP, WR0, WR1, WR2, DONE} state_t;
  state_t state;

  logic [AW-1:0] p;
  logic [SW-1:0] sum;
  logic [BW-1:0] thr_l;
  logic [SW-1:0] sum_q;
  logic [SW-1:0] thr3;
  logic [BW-1:0] pix;
  logic          last;

  assign RAM_wen1 = 1'b0;
  assign RAM_ren2 = 1'b0;
  assign RAM_D1   = '0;

  always_comb begin
    sum_q = sum + SW'(RAM_Q1);
    thr3  = {2'b00, thr_l} * SW'(3);
    pix   = (sum >= thr3) ? {BW{1'b1}} : {BW{1'b0}};
    // p still points at the pixel just written, so the next one must fit in p+3..p+5
    last  = ({1'b0, p} + (AW+1)'(6)) > END_X;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      p         <= P0;
      sum       <= '0;
      thr_l     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      RAM_ren1  <= 1'b0;
      RAM_addr1 <= '0;
      RAM_wen2  <= 1'b0;
      RAM_addr2 <= '0;
      RAM_D2    <= '0;
`ifdef BIN_WHITE_CNT_EN
      white_cnt <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          thr_l <= thr;
          p     <= P0;
          sum   <= '0;
          busy  <= 1'b1;
`ifdef BIN_WHITE_CNT_EN
          white_cnt <= '0;
`endif
          if (EMPTY) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state     <= RD0;
            RAM_ren1  <= 1'b1;
            RAM_addr1 <= P0;
          end
        end
        RD0: begin
          RAM_addr1 <= p + AW'(1);
          state     <= RD1;
        end
        RD1: begin
          sum       <= sum_q;
          RAM_addr1 <= p + AW'(2);
          state     <= RD2;
        end
        RD2: begin
          sum   <= sum_q;
          state <= RD3;
        end
        RD3: begin
          sum      <= sum_q;
          RAM_ren1 <= 1'b0;
          state    <= CMP;
        end
        CMP: begin
          RAM_wen2  <= 1'b1;
          RAM_addr2 <= p;
          RAM_D2    <= pix;
`ifdef BIN_WHITE_CNT_EN
          if (pix[0]) white_cnt <= white_cnt + AW'(1);
`endif
          state <= WR0;
        end
        WR0: begin
          RAM_addr2 <= p + AW'(1);
          state     <= WR1;
        end
        WR1: begin
          RAM_addr2 <= p + AW'(2);
          state     <= WR2;
        end
        WR2: begin
          RAM_wen2 <= 1'b0;
          sum      <= '0;
          p        <= p + AW'(3);
          if (last) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state     <= RD0;
            RAM_ren1  <= 1'b1;
            RAM_addr1 <= p + AW'(3);
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
